// File: rtl/uart_tx.sv
// uart_tx: serial transmitter, start + 8 data bits (LSB first) + optional parity + STOP_BITS stop bits.
// Latency: tx_o follows the state register by one clock; every bit lasts 16*(div+1) clocks.
// Backpressure: tx_ready_o is high only in Idle; tx_valid_i is ignored (must be held) while busy.
// Optional parity bit after the data bits is compiled in by defining UART_TX_PARITY_EN.
module uart_tx #(
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [10:0] div_i,
  input  logic        tx_valid_i,
  input  logic [7:0]  data_i,
  output logic        tx_ready_o,
  output logic        tx_o,
  output logic        tx_busy_o,
  output logic        tx_done_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Value of the stop-bit counter during the final stop bit.
  localparam logic LAST_STOP = (STOP_BITS == 2);

  state_t      state;
  state_t      state_nxt;
  logic [10:0] div_lat;
  logic [10:0] div_cnt;
  logic [3:0]  tick_cnt;
  logic [2:0]  bit_cnt;
  logic        stop_cnt;
  logic [7:0]  shift;
  logic        tx_lvl;
  logic        xfer;
  logic        tick;
  logic        bit_end;

  assign tx_ready_o = (state == S_IDLE);
  assign tx_busy_o  = ~tx_ready_o;
  assign xfer       = tx_valid_i & tx_ready_o;
  assign tick       = (div_cnt == div_lat);
  assign bit_end    = tick & (tick_cnt == 4'd15);

`ifdef UART_TX_PARITY_EN
  logic [7:0] data_lat;
  logic       par_bit;

  assign par_bit = (^data_lat) ^ PARITY_ODD;

  // Keep the whole byte for the parity bit; the shift register is consumed by then.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_lat <= 8'd0;
    end else if (xfer) begin
      data_lat <= data_i;
    end
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Baud/tick/bit counters and data shifter; everything restarts at the handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_lat  <= 11'd0;
      div_cnt  <= 11'd0;
      tick_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
      stop_cnt <= 1'b0;
      shift    <= 8'd0;
    end else if (xfer) begin
      div_lat  <= div_i;
      div_cnt  <= 11'd0;
      tick_cnt <= 4'd0;
      bit_cnt  <= 3'd0;
      stop_cnt <= 1'b0;
      shift    <= data_i;
    end else if (state != S_IDLE) begin
      div_cnt <= tick ? 11'd0 : div_cnt + 11'd1;
      if (tick) begin
        tick_cnt <= tick_cnt + 4'd1;
      end
      if (bit_end && state == S_DATA) begin
        shift   <= {1'b0, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (bit_end && state == S_STOP) begin
        stop_cnt <= stop_cnt + 1'b1;
      end
    end
  end

  // Next state, line level for the current state, and the end-of-frame pulse.
  always_comb begin
    state_nxt = state;
    tx_lvl    = 1'b1;
    tx_done_o = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_valid_i) begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        tx_lvl = 1'b0;
        if (bit_end) begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        tx_lvl = shift[0];
        if (bit_end && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        tx_lvl = par_bit;
        if (bit_end) begin
          state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end && stop_cnt == LAST_STOP) begin
          tx_done_o = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered line driver; reset forces the line idle-high immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_o <= 1'b1;
    end else begin
      tx_o <= tx_lvl;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (STOP_BITS 1 and 2) share stimulus.
// A frame-level model predicts every output on every cycle; directed tests pin it with literals.
`timescale 1ns/1ps
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic [10:0] div   = 11'd0;
  logic        valid = 1'b0;
  logic [7:0]  data  = 8'd0;
  logic        tx_w   [2];
  logic        rdy_w  [2];
  logic        busy_w [2];
  logic        done_w [2];

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt [2] = '{0, 0};
  int run_len  [2][4];

  // Model state: one frame description per instance.
  bit m_act   [2] = '{1'b0, 1'b0};
  int m_k     [2] = '{0, 0};
  int m_bl    [2] = '{16, 16};
  int m_total [2] = '{0, 0};
  int m_xfers [2] = '{0, 0};
  bit m_lvl   [2][12];

  uart_tx #(.STOP_BITS(1), .PARITY_ODD(1'b0)) u0 (
    .clk_i(clk), .rst_i(rst), .div_i(div), .tx_valid_i(valid), .data_i(data),
    .tx_ready_o(rdy_w[0]), .tx_o(tx_w[0]), .tx_busy_o(busy_w[0]), .tx_done_o(done_w[0])
  );

  uart_tx #(.STOP_BITS(2), .PARITY_ODD(1'b0)) u1 (
    .clk_i(clk), .rst_i(rst), .div_i(div), .tx_valid_i(valid), .data_i(data),
    .tx_ready_o(rdy_w[1]), .tx_o(tx_w[1]), .tx_busy_o(busy_w[1]), .tx_done_o(done_w[1])
  );

  always #5 clk = ~clk;

  // Frame model: at a handshake build the list of bit levels and the frame length;
  // m_k counts clocks since the handshake edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < 2; u++) m_act[u] = 1'b0;
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (m_act[u]) begin
          m_k[u] = m_k[u] + 1;
          if (m_k[u] >= m_total[u]) m_act[u] = 1'b0;
        end else if (valid) begin
          m_bl[u] = 16 * (int'(div) + 1);
          m_lvl[u][0] = 1'b0;
          for (int i = 0; i < 8; i++) m_lvl[u][1+i] = data[i];
          for (int i = 9; i < 12; i++) m_lvl[u][i] = 1'b1;
          if (PAR == 1) m_lvl[u][9] = ^data;
          m_total[u] = (9 + PAR + u + 1) * m_bl[u];
          m_k[u]     = 0;
          m_act[u]   = 1'b1;
          m_xfers[u] = m_xfers[u] + 1;
        end
      end
    end
  end

  function automatic logic exp_tx(input int u);
    if (!m_act[u] || m_k[u] == 0) return 1'b1;
    return m_lvl[u][(m_k[u] - 1) / m_bl[u]];
  endfunction

  // Every-cycle comparison of all outputs against the model.
  logic [3:0] got_v, req_v;
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      got_v = {tx_w[u], rdy_w[u], busy_w[u], done_w[u]};
      req_v = {exp_tx(u), !m_act[u], m_act[u], m_act[u] && (m_k[u] == m_total[u] - 1)};
      n_tests++;
      if (got_v !== req_v) begin
        n_fail++;
        $display("FAIL model u%0d t=%0t tx/rdy/busy/done got %b required %b", u, $time, got_v, req_v);
      end
      if (done_w[u] === 1'b1) done_cnt[u]++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, got, got, req, req);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL timeout %s: got no event required event within bound", name);
  endtask

  // Offer a byte and hold valid until both instances have taken it.
  task automatic send(input logic [7:0] b);
    int x0, x1, t;
    x0 = m_xfers[0]; x1 = m_xfers[1]; t = 0;
    data = b; valid = 1'b1;
    while ((m_xfers[0] == x0 || m_xfers[1] == x1) && t < 5000) begin
      @(negedge clk); t++;
    end
    valid = 1'b0;
    if (t >= 5000) timeout("send");
  endtask

  task automatic wait_xfers(input int n0, input int n1);
    int t;
    t = 0;
    while ((m_xfers[0] < n0 || m_xfers[1] < n1) && t < 5000) begin
      @(negedge clk); t++;
    end
    if (t >= 5000) timeout("wait_xfers");
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((m_act[0] || m_act[1]) && t < 50000) begin
      @(negedge clk); t++;
    end
    if (t >= 50000) timeout("wait_idle");
    @(negedge clk);
  endtask

  // Sample mid-bit levels of one frame and measure first-low to ready-high length.
  task automatic capture(input int u, input int bl, output logic [11:0] bits, output int flen);
    int t, c;
    bits = '0; flen = 0; t = 0;
    while (tx_w[u] !== 1'b0 && t < 5000) begin
      @(negedge clk); t++;
    end
    if (t >= 5000) begin
      timeout("capture start");
    end else begin
      c = 0;
      while (rdy_w[u] !== 1'b1 && c < 40000) begin
        if (c % bl == bl / 2 && c / bl < 12) bits[c/bl] = tx_w[u];
        @(negedge clk); c++;
      end
      if (c >= 40000) timeout("capture end");
      flen = c + 1;
    end
  endtask

  // Lengths of the first four constant-level runs starting at the first low.
  task automatic runs(input int u);
    int t;
    logic lvl;
    t = 0;
    while (tx_w[u] !== 1'b0 && t < 5000) begin
      @(negedge clk); t++;
    end
    lvl = 1'b0;
    for (int j = 0; j < 4; j++) begin
      run_len[u][j] = 0;
      while (tx_w[u] === lvl && t < 40000) begin
        @(negedge clk); run_len[u][j]++; t++;
      end
      lvl = ~lvl;
    end
    if (t >= 40000) timeout("runs");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

  logic [11:0] b0, b1;
  int f0, f1, dc;

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("reset tx", tx_w[u], 1);
      check("reset ready", rdy_w[u], 1);
      check("reset busy", busy_w[u], 0);
      check("reset done", done_w[u], 0);
    end
    #1 rst = 1'b0;
    @(negedge clk);

    // 1 + 5: 0x55 and 0x3C at div 0.
    div = 11'd0;
    fork
      capture(0, 16, b0, f0);
      send(8'h55);
    join
    wait_idle();
    check("t1 start", b0[0], 0);
    check("t1 data", b0[8:1], 8'h55);
    check("t1 stop", b0[9+PAR], 1);
    check("t1 frame len", f0, (PAR == 1) ? 176 : 160);
    check("t1 done count", done_cnt[0], 1);

    fork
      capture(1, 16, b1, f1);
      send(8'h3C);
    join
    wait_idle();
    check("t5 data", b1[8:1], 8'h3C);
    check("t5 stop1", b1[9+PAR], 1);
    check("t5 stop2", b1[10+PAR], 1);
    check("t5 frame len", f1, (PAR == 1) ? 192 : 176);

    // 2: back-to-back 0x80, 0x01 at div 3 with valid held.
    div = 11'd3;
    fork
      runs(0);
      runs(1);
      begin
        dc = m_xfers[0];
        data = 8'h80; valid = 1'b1;
        wait_xfers(dc + 1, dc + 1);
        data = 8'h01;
        wait_xfers(dc + 2, dc + 2);
        valid = 1'b0;
      end
    join
    wait_idle();
    check("t2 first low run", run_len[0][0], 512);
    check("t2 msb+stop+gap", run_len[0][1], (PAR == 1) ? 193 : 129);
    check("t2 second start", run_len[0][2], 64);
    check("t2 stop2 high run", run_len[1][1], (PAR == 1) ? 257 : 193);

    // 3: divider change mid-frame only affects the next frame.
    div = 11'd0;
    fork
      capture(0, 16, b0, f0);
      send(8'hA5);
      begin
        repeat (60) @(negedge clk);
        div = 11'd7;
      end
    join
    wait_idle();
    check("t3 data", b0[8:1], 8'hA5);
    check("t3 frame len", f0, (PAR == 1) ? 176 : 160);
    fork
      capture(0, 128, b0, f0);
      send(8'h5A);
    join
    wait_idle();
    check("t3 next data", b0[8:1], 8'h5A);
    check("t3 next frame len", f0, (10 + PAR) * 128);

    // 4: reset mid-frame, first during data bit 4 of 0xFF, then during a start bit.
    div = 11'd0;
    dc = done_cnt[0];
    send(8'hFF);
    repeat (88) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("t4 tx", tx_w[0], 1);
    check("t4 ready", rdy_w[0], 1);
    check("t4 busy", busy_w[0], 0);
    check("t4 done", done_w[0], 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    send(8'h00);
    repeat (4) @(negedge clk);
    check("t4 start low", tx_w[0], 0);
    #1 rst = 1'b1;
    #1;
    check("t4 async tx", tx_w[0], 1);
    check("t4 async tx stop2", tx_w[1], 1);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t4 no done pulse", done_cnt[0], dc);
    fork
      capture(0, 16, b0, f0);
      send(8'h00);
    join
    wait_idle();
    check("t4 after data", b0[8:1], 8'h00);
    check("t4 after stop", b0[9+PAR], 1);
    check("t4 after len", f0, (PAR == 1) ? 176 : 160);
    check("t4 one done", done_cnt[0], dc + 1);

`ifdef UART_TX_PARITY_EN
    // 6: even parity.
    fork
      capture(0, 16, b0, f0);
      send(8'h07);
    join
    wait_idle();
    check("t6 parity 07", b0[9], 1);
    check("t6 len", f0, 176);
    fork
      capture(0, 16, b0, f0);
      send(8'h03);
    join
    wait_idle();
    check("t6 parity 03", b0[9], 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
